// File: rtl/fem_trig_gen.sv
`default_nettype none
// ============================================================================
// Module   : fem_trig_gen
// Purpose  : Internal FEM fast-command generator. Provides the BX counter with
//            per-orbit BC0, L1A bursts with match prescale, and RESYNC
//            sequencing. Define FEM_TRIG_RANDOM_EN for LFSR-driven L1A timing.
// Revision : 1.0  initial release
// ============================================================================
module fem_trig_gen #(
    parameter int ORBIT_LEN  = 3564,
    parameter int BC0_BX     = 0,
    parameter int RESYNC_GAP = 16
) (
    input  logic        CLK40,
    input  logic        RST,
    input  logic        ENABLE,
    input  logic        START,
    input  logic        RESYNC_REQ,
    input  logic [15:0] L1A_PERIOD,
    input  logic [3:0]  MATCH_EVERY,
    input  logic [15:0] BURST_CNT,
    output logic        FEM_L1A,
    output logic        FEM_L1A_MATCH,
    output logic        FEM_RESYNC,
    output logic        FEM_BC0,
    output logic [11:0] BX_CNT,
    output logic [23:0] L1A_CNT,
    output logic        BUSY,
    output logic        DONE
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd2,
        S_RSYNC = 2'd3
    } state_t;

    localparam logic [11:0] c_BX_LAST  = 12'(ORBIT_LEN - 1);
    localparam logic [11:0] c_BC0_BX   = 12'(BC0_BX);
    localparam logic [15:0] c_GAP_LAST = 16'(RESYNC_GAP - 1);

    state_t      r_state;
    state_t      r_ret_state;
    state_t      w_state_nxt;
    logic [15:0] r_period;
    logic [3:0]  r_match_every;
    logic [15:0] r_burst;
    logic [15:0] r_period_cnt;
    logic [3:0]  r_match_cnt;
    logic [15:0] r_gap_cnt;
    logic [11:0] r_bx;
    logic [23:0] r_l1a_cnt;
    logic        r_l1a;
    logic        r_match;
    logic        r_resync;
    logic        r_bc0;

    logic        w_start_acc;
    logic        w_rsync_enter;
    logic        w_rsync_exit;
    logic        w_issue;
    logic        w_due;
    logic        w_match_hit;
    logic        w_burst_done;
    logic [15:0] w_eff_period;

    assign w_eff_period = (L1A_PERIOD < 16'd2) ? 16'd2 : L1A_PERIOD;
    assign w_match_hit  = (r_match_every <= 4'd1) || ((r_match_cnt + 4'd1) == r_match_every);
    assign w_burst_done = (r_burst != 16'd0) && (r_l1a_cnt == {8'd0, r_burst});

`ifdef FEM_TRIG_RANDOM_EN
    logic [15:0] r_lfsr;
    logic        r_holdoff;

    // r_period holds the raw rate threshold in this mode
    assign w_due = (r_lfsr < r_period) && !r_holdoff;

    always_ff @(posedge CLK40 or posedge RST) begin
        if (RST) begin
            r_lfsr    <= 16'hACE1;
            r_holdoff <= 1'b0;
        end else begin
            r_lfsr    <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            r_holdoff <= w_issue;
        end
    end
`else
    assign w_due = (r_period_cnt <= 16'd1);
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_start_acc   = 1'b0;
        w_rsync_enter = 1'b0;
        w_rsync_exit  = 1'b0;
        w_issue       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (RESYNC_REQ)
                    w_rsync_enter = 1'b1;
                else if (START && ENABLE)
                    w_start_acc = 1'b1;
            end
            S_RUN: begin
                if (RESYNC_REQ)
                    w_rsync_enter = 1'b1;
                else if (!ENABLE)
                    w_state_nxt = S_IDLE;
                else if (w_burst_done)
                    w_state_nxt = S_DONE;
                else
                    w_issue = w_due;
            end
            S_DONE: begin
                if (RESYNC_REQ)
                    w_rsync_enter = 1'b1;
                else if (!ENABLE)
                    w_state_nxt = S_IDLE;
                else if (START)
                    w_start_acc = 1'b1;
            end
            S_RSYNC: begin
                if (r_gap_cnt == 16'd0) begin
                    w_rsync_exit = 1'b1;
                    w_state_nxt  = ENABLE ? r_ret_state : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_rsync_enter)
            w_state_nxt = S_RSYNC;
        if (w_start_acc)
            w_state_nxt = S_RUN;
    end

    always_ff @(posedge CLK40 or posedge RST) begin
        if (RST) begin
            r_state       <= S_IDLE;
            r_ret_state   <= S_IDLE;
            r_period      <= '0;
            r_match_every <= '0;
            r_burst       <= '0;
            r_period_cnt  <= '0;
            r_match_cnt   <= '0;
            r_gap_cnt     <= '0;
            r_bx          <= '0;
            r_l1a_cnt     <= '0;
            r_l1a         <= 1'b0;
            r_match       <= 1'b0;
            r_resync      <= 1'b0;
            r_bc0         <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_l1a    <= w_issue;
            r_match  <= w_issue && w_match_hit;
            r_resync <= w_rsync_enter;
            r_bc0    <= (r_bx == c_BC0_BX);

            if (w_rsync_enter || (r_bx == c_BX_LAST))
                r_bx <= '0;
            else
                r_bx <= r_bx + 12'd1;

            if (w_rsync_enter) begin
                r_ret_state <= r_state;
                r_gap_cnt   <= c_GAP_LAST;
            end else if ((r_state == S_RSYNC) && (r_gap_cnt != 16'd0)) begin
                r_gap_cnt <= r_gap_cnt - 16'd1;
            end

            if (w_start_acc) begin
`ifdef FEM_TRIG_RANDOM_EN
                r_period      <= L1A_PERIOD;
`else
                r_period      <= w_eff_period;
`endif
                r_match_every <= MATCH_EVERY;
                r_burst       <= BURST_CNT;
                r_match_cnt   <= '0;
            end else if (w_issue) begin
                r_match_cnt <= w_match_hit ? 4'd0 : (r_match_cnt + 4'd1);
            end

            if (w_start_acc || w_rsync_enter)
                r_l1a_cnt <= '0;
            else if (w_issue)
                r_l1a_cnt <= r_l1a_cnt + 24'd1;

            // The START cycle itself counts toward the first period, hence P-1
            if (w_start_acc)
                r_period_cnt <= w_eff_period - 16'd1;
            else if (w_issue || w_rsync_exit)
                r_period_cnt <= r_period;
            else if ((r_state == S_RUN) && (r_period_cnt != 16'd0))
                r_period_cnt <= r_period_cnt - 16'd1;
        end
    end

    assign FEM_L1A       = r_l1a;
    assign FEM_L1A_MATCH = r_match;
    assign FEM_RESYNC    = r_resync;
    assign FEM_BC0       = r_bc0;
    assign BX_CNT        = r_bx;
    assign L1A_CNT       = r_l1a_cnt;
    assign BUSY          = (r_state == S_RUN) || (r_state == S_RSYNC);
    assign DONE          = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_fem_trig_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fem_trig_gen
// Purpose  : Scoreboard bench for fem_trig_gen (periodic build).
// Revision : 1.0  initial release
// ============================================================================
module tb_fem_trig_gen;

    logic        CLK40;
    logic        RST;
    logic        ENABLE;
    logic        START;
    logic        RESYNC_REQ;
    logic [15:0] L1A_PERIOD;
    logic [3:0]  MATCH_EVERY;
    logic [15:0] BURST_CNT;
    logic        FEM_L1A;
    logic        FEM_L1A_MATCH;
    logic        FEM_RESYNC;
    logic        FEM_BC0;
    logic [11:0] BX_CNT;
    logic [23:0] L1A_CNT;
    logic        BUSY;
    logic        DONE;

    fem_trig_gen dut (
        .CLK40        (CLK40),
        .RST          (RST),
        .ENABLE       (ENABLE),
        .START        (START),
        .RESYNC_REQ   (RESYNC_REQ),
        .L1A_PERIOD   (L1A_PERIOD),
        .MATCH_EVERY  (MATCH_EVERY),
        .BURST_CNT    (BURST_CNT),
        .FEM_L1A      (FEM_L1A),
        .FEM_L1A_MATCH(FEM_L1A_MATCH),
        .FEM_RESYNC   (FEM_RESYNC),
        .FEM_BC0      (FEM_BC0),
        .BX_CNT       (BX_CNT),
        .L1A_CNT      (L1A_CNT),
        .BUSY         (BUSY),
        .DONE         (DONE)
    );

    typedef struct {
        int cyc;
        bit match;
        int cnt;
    } l1a_exp_t;

    l1a_exp_t l1a_q[$];
    int       rs_q[$];
    int       bc0_q[$];
    int       checks   = 0;
    int       failures = 0;
    int       cyc      = 0;
    int       r0       = 0;

    initial CLK40 = 1'b0;
    always #12.5 CLK40 = ~CLK40;

    always @(posedge CLK40) cyc <= cyc + 1;

    // L1A / RESYNC scoreboard monitor
    l1a_exp_t me;
    int       mr;
    always @(negedge CLK40) begin
        if (!RST) begin
            if (FEM_L1A) begin
                checks++;
                if (l1a_q.size() == 0) begin
                    failures++;
                    $display("FAIL l1a_unexpected cycle=%0d actual=1 required=0", cyc - r0);
                end else begin
                    me = l1a_q.pop_front();
                    if (cyc !== me.cyc) begin
                        failures++;
                        $display("FAIL l1a_cycle actual=%0d required=%0d", cyc - r0, me.cyc - r0);
                    end
                    checks++;
                    if (FEM_L1A_MATCH !== me.match) begin
                        failures++;
                        $display("FAIL l1a_match cycle=%0d actual=%0b required=%0b", cyc - r0, FEM_L1A_MATCH, me.match);
                    end
                    checks++;
                    if (L1A_CNT !== 24'(me.cnt)) begin
                        failures++;
                        $display("FAIL l1a_cnt cycle=%0d actual=%0d required=%0d", cyc - r0, L1A_CNT, me.cnt);
                    end
                end
            end else if (FEM_L1A_MATCH) begin
                checks++;
                failures++;
                $display("FAIL match_without_l1a cycle=%0d actual=1 required=0", cyc - r0);
            end
            if (FEM_RESYNC) begin
                checks++;
                if (rs_q.size() == 0) begin
                    failures++;
                    $display("FAIL resync_unexpected cycle=%0d actual=1 required=0", cyc - r0);
                end else begin
                    mr = rs_q.pop_front();
                    if (cyc !== mr) begin
                        failures++;
                        $display("FAIL resync_cycle actual=%0d required=%0d", cyc - r0, mr - r0);
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge CLK40);
    endtask

    task automatic test_reset();
        RST = 1'b1; ENABLE = 1'b0; START = 1'b0; RESYNC_REQ = 1'b0;
        L1A_PERIOD = '0; MATCH_EVERY = '0; BURST_CNT = '0;
        repeat (3) @(negedge CLK40);
        checks++;
        if ({FEM_L1A, FEM_L1A_MATCH, FEM_RESYNC, FEM_BC0, BUSY, DONE} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags actual=%b required=000000", {FEM_L1A, FEM_L1A_MATCH, FEM_RESYNC, FEM_BC0, BUSY, DONE});
        end
        checks++;
        if (BX_CNT !== 12'd0) begin
            failures++;
            $display("FAIL reset_bx actual=%0d required=0", BX_CNT);
        end
        checks++;
        if (L1A_CNT !== 24'd0) begin
            failures++;
            $display("FAIL reset_l1a_cnt actual=%0d required=0", L1A_CNT);
        end
        RST = 1'b0;
        r0  = cyc;
    endtask

    task automatic test_orbit();
        int n, mx, e;
        mx = 0;
        bc0_q.push_back(r0 + 1);
        bc0_q.push_back(r0 + 1 + 3564);
        bc0_q.push_back(r0 + 1 + 2 * 3564);
        while (cyc < r0 + 7131) begin
            @(negedge CLK40);
            n = cyc - r0;
            if (int'(BX_CNT) > mx) mx = int'(BX_CNT);
            if (FEM_BC0) begin
                checks++;
                if (bc0_q.size() == 0) begin
                    failures++;
                    $display("FAIL bc0_unexpected cycle=%0d actual=1 required=0", n);
                end else begin
                    e = bc0_q.pop_front();
                    if (cyc !== e) begin
                        failures++;
                        $display("FAIL bc0_cycle actual=%0d required=%0d", n, e - r0);
                    end
                end
            end
            if (n == 1 || n == 3563 || n == 3564) begin
                checks++;
                if (BX_CNT !== 12'(n % 3564)) begin
                    failures++;
                    $display("FAIL bx_value cycle=%0d actual=%0d required=%0d", n, BX_CNT, n % 3564);
                end
            end
        end
        checks++;
        if (mx !== 3563) begin
            failures++;
            $display("FAIL bx_max actual=%0d required=3563", mx);
        end
        checks++;
        if (bc0_q.size() !== 0) begin
            failures++;
            $display("FAIL bc0_missing actual=%0d required=0", bc0_q.size());
        end
    endtask

    task automatic test_burst();
        int c0;
        @(negedge CLK40);
        ENABLE = 1'b1; L1A_PERIOD = 16'd10; MATCH_EVERY = 4'd0; BURST_CNT = 16'd5; START = 1'b1;
        c0 = cyc;
        for (int k = 1; k <= 5; k++) l1a_q.push_back('{c0 + 10 * k, 1'b1, k});
        @(negedge CLK40);
        START = 1'b0; L1A_PERIOD = 16'd3; BURST_CNT = 16'd2;
        checks++;
        if (BUSY !== 1'b1) begin
            failures++;
            $display("FAIL burst_busy_rise actual=%0b required=1", BUSY);
        end
        wait_cyc(c0 + 50);
        checks++;
        if (DONE !== 1'b0) begin
            failures++;
            $display("FAIL burst_done_early actual=%0b required=0", DONE);
        end
        wait_cyc(c0 + 51);
        checks++;
        if (DONE !== 1'b1 || BUSY !== 1'b0) begin
            failures++;
            $display("FAIL burst_done actual=done%0b/busy%0b required=done1/busy0", DONE, BUSY);
        end
        checks++;
        if (L1A_CNT !== 24'd5) begin
            failures++;
            $display("FAIL burst_l1a_cnt actual=%0d required=5", L1A_CNT);
        end
        checks++;
        if (l1a_q.size() !== 0) begin
            failures++;
            $display("FAIL burst_missing_l1a actual=%0d required=0", l1a_q.size());
        end
    endtask

    task automatic test_match();
        int c0;
        @(negedge CLK40);
        L1A_PERIOD = 16'd4; MATCH_EVERY = 4'd3; BURST_CNT = 16'd9; START = 1'b1;
        c0 = cyc;
        for (int k = 1; k <= 9; k++) l1a_q.push_back('{c0 + 4 * k, (k % 3) == 0, k});
        @(negedge CLK40);
        START = 1'b0;
        wait_cyc(c0 + 10);
        START = 1'b1;
        @(negedge CLK40);
        START = 1'b0;
        wait_cyc(c0 + 37);
        checks++;
        if (DONE !== 1'b1 || L1A_CNT !== 24'd9) begin
            failures++;
            $display("FAIL match_done actual=done%0b/cnt%0d required=done1/cnt9", DONE, L1A_CNT);
        end
        checks++;
        if (l1a_q.size() !== 0) begin
            failures++;
            $display("FAIL match_missing_l1a actual=%0d required=0", l1a_q.size());
        end
    endtask

    task automatic test_resync();
        int c0, r;
        @(negedge CLK40);
        L1A_PERIOD = 16'd5; MATCH_EVERY = 4'd0; BURST_CNT = 16'd0; START = 1'b1;
        c0 = cyc;
        l1a_q.push_back('{c0 + 5, 1'b1, 1});
        l1a_q.push_back('{c0 + 10, 1'b1, 2});
        @(negedge CLK40);
        START = 1'b0;
        wait_cyc(c0 + 14);
        RESYNC_REQ = 1'b1;
        r = cyc;
        rs_q.push_back(r + 1);
        l1a_q.push_back('{r + 22, 1'b1, 1});
        l1a_q.push_back('{r + 27, 1'b1, 2});
        @(negedge CLK40);
        RESYNC_REQ = 1'b0;
        checks++;
        if (BX_CNT !== 12'd0 || L1A_CNT !== 24'd0) begin
            failures++;
            $display("FAIL resync_clear actual=bx%0d/cnt%0d required=bx0/cnt0", BX_CNT, L1A_CNT);
        end
        checks++;
        if (BUSY !== 1'b1) begin
            failures++;
            $display("FAIL resync_busy actual=%0b required=1", BUSY);
        end
        @(negedge CLK40);
        checks++;
        if (BX_CNT !== 12'd1) begin
            failures++;
            $display("FAIL resync_bx_next actual=%0d required=1", BX_CNT);
        end
        wait_cyc(r + 28);
        ENABLE = 1'b0;
        wait_cyc(r + 40);
        checks++;
        if (BUSY !== 1'b0) begin
            failures++;
            $display("FAIL resync_disable_idle actual=%0b required=0", BUSY);
        end
        checks++;
        if (l1a_q.size() !== 0 || rs_q.size() !== 0) begin
            failures++;
            $display("FAIL resync_missing actual=%0d required=0", l1a_q.size() + rs_q.size());
        end
    endtask

    task automatic test_resync_start();
        int s;
        @(negedge CLK40);
        ENABLE = 1'b1; L1A_PERIOD = 16'd2; BURST_CNT = 16'd0; START = 1'b1; RESYNC_REQ = 1'b1;
        s = cyc;
        rs_q.push_back(s + 1);
        @(negedge CLK40);
        START = 1'b0; RESYNC_REQ = 1'b0;
        checks++;
        if (BUSY !== 1'b1 || L1A_CNT !== 24'd0) begin
            failures++;
            $display("FAIL rs_start_enter actual=busy%0b/cnt%0d required=busy1/cnt0", BUSY, L1A_CNT);
        end
        wait_cyc(s + 17);
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            failures++;
            $display("FAIL rs_start_idle actual=busy%0b/done%0b required=busy0/done0", BUSY, DONE);
        end
        wait_cyc(s + 40);
        checks++;
        if (rs_q.size() !== 0) begin
            failures++;
            $display("FAIL rs_start_missing actual=%0d required=0", rs_q.size());
        end
    endtask

    task automatic test_rst_mid_burst();
        int c0;
        @(negedge CLK40);
        L1A_PERIOD = 16'd3; MATCH_EVERY = 4'd0; BURST_CNT = 16'd0; START = 1'b1;
        c0 = cyc;
        for (int k = 1; k <= 3; k++) l1a_q.push_back('{c0 + 3 * k, 1'b1, k});
        @(negedge CLK40);
        START = 1'b0;
        wait_cyc(c0 + 9);
        #2 RST = 1'b1;
        #1;
        checks++;
        if (FEM_L1A !== 1'b0 || FEM_L1A_MATCH !== 1'b0 || BUSY !== 1'b0) begin
            failures++;
            $display("FAIL rst_flags actual=l1a%0b/m%0b/busy%0b required=000", FEM_L1A, FEM_L1A_MATCH, BUSY);
        end
        checks++;
        if (L1A_CNT !== 24'd0 || BX_CNT !== 12'd0) begin
            failures++;
            $display("FAIL rst_counters actual=cnt%0d/bx%0d required=0/0", L1A_CNT, BX_CNT);
        end
        @(negedge CLK40);
        RST = 1'b0;
        repeat (20) @(negedge CLK40);
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || l1a_q.size() !== 0) begin
            failures++;
            $display("FAIL rst_idle actual=busy%0b/done%0b/q%0d required=0/0/0", BUSY, DONE, l1a_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        @(negedge CLK40);
        L1A_PERIOD = 16'd1; MATCH_EVERY = 4'd1; BURST_CNT = 16'd4; START = 1'b1;
        c0 = cyc;
        for (int k = 1; k <= 4; k++) l1a_q.push_back('{c0 + 2 * k, 1'b1, k});
        @(negedge CLK40);
        START = 1'b0;
        wait_cyc(c0 + 8);
        checks++;
        if (DONE !== 1'b0) begin
            failures++;
            $display("FAIL p1_done_early actual=%0b required=0", DONE);
        end
        @(negedge CLK40);
        checks++;
        if (DONE !== 1'b1) begin
            failures++;
            $display("FAIL p1_done actual=%0b required=1", DONE);
        end
        L1A_PERIOD = 16'd0; MATCH_EVERY = 4'd2; BURST_CNT = 16'd2; START = 1'b1;
        c0 = cyc;
        l1a_q.push_back('{c0 + 2, 1'b0, 1});
        l1a_q.push_back('{c0 + 4, 1'b1, 2});
        @(negedge CLK40);
        START = 1'b0;
        wait_cyc(c0 + 5);
        checks++;
        if (DONE !== 1'b1 || L1A_CNT !== 24'd2) begin
            failures++;
            $display("FAIL b2b_done actual=done%0b/cnt%0d required=done1/cnt2", DONE, L1A_CNT);
        end
        checks++;
        if (l1a_q.size() !== 0) begin
            failures++;
            $display("FAIL b2b_missing_l1a actual=%0d required=0", l1a_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_orbit();
        test_burst();
        test_match();
        test_resync();
        test_resync_start();
        test_rst_mid_burst();
        test_back_to_back();
        repeat (4) @(negedge CLK40);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
